// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic-unit sequencer: op codes, FSM states
// and datapath widths.
package arith_pkg;

   localparam int AU_W   = 16;
   localparam int WIDE_W = 32;

   localparam logic [2:0] OP_SADD = 3'b000;
   localparam logic [2:0] OP_UADD = 3'b001;
   localparam logic [2:0] OP_SSUB = 3'b010;
   localparam logic [2:0] OP_USUB = 3'b011;
   localparam logic [2:0] OP_INC  = 3'b100;
   localparam logic [2:0] OP_DEC  = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      RESP = 2'd3
   } state_t;

   // Codes 110 and 111 have no arithmetic meaning.
   function automatic logic op_illegal(input logic [2:0] op);
      return op[2] & op[1];
   endfunction

endpackage

// File: rtl/arith_op_map.sv
// Translates a command plus pass index into the operand/code/carry inputs
// of the 16-bit arithmetic unit. Purely combinational.
module arith_op_map
   import arith_pkg::*;
(
   input  logic [2:0]        op,
   input  logic              wide,
   input  logic              pass,     // 0 = low half, 1 = high half
   input  logic              carry,    // carry out of the low pass
   input  logic              cin,
   input  logic [WIDE_W-1:0] a,
   input  logic [WIDE_W-1:0] b,
   output logic [AU_W-1:0]   au_a,
   output logic [AU_W-1:0]   au_b,
   output logic [2:0]        au_code,
   output logic              au_cin
);

   // Select the half-word operands and the code each pass must present.
   // NOTE: every output gets a default first so no path can infer a latch.
   always_comb begin
      au_a    = pass ? a[31:16] : a[15:0];
      au_b    = '0;
      au_code = '0;
      au_cin  = 1'b0;
      if (!wide) begin
         au_b    = b[15:0];
         au_code = op;
         au_cin  = cin;
      end else if (!pass) begin
         // Low pass is always unsigned so the carry chains cleanly upward.
         case (op)
            OP_SADD, OP_UADD: begin
               au_b    = b[15:0];
               au_code = OP_UADD;
               au_cin  = cin;
            end
            OP_SSUB, OP_USUB: begin
               au_b    = b[15:0];
               au_code = OP_USUB;
               au_cin  = cin;
            end
            OP_INC: begin
               au_b    = '0;
               au_code = OP_UADD;
               au_cin  = 1'b1;
            end
            OP_DEC: begin
               au_b    = 16'd1;
               au_code = OP_USUB;
               au_cin  = 1'b1;
            end
            default: ;
         endcase
      end else begin
         // High pass keeps the requested signedness so vout is meaningful.
         case (op)
            OP_SADD, OP_UADD, OP_SSUB, OP_USUB: begin
               au_b    = b[31:16];
               au_code = op;
               au_cin  = carry;
            end
            OP_INC: begin
               au_b    = '0;
               au_code = OP_SADD;
               au_cin  = carry;
            end
            OP_DEC: begin
               au_b    = '0;
               au_code = OP_SSUB;
               au_cin  = carry;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/arith_chain_ctrl.sv
// Sequencer in front of the combinational 16-bit arithmetic unit: accepts a
// command, holds operands for SETTLE_CYCLES per pass, chains two passes for
// 32-bit operations and returns the result over a valid/ready handshake.
module arith_chain_ctrl
   import arith_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1,
   parameter int WIDE_EN       = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [31:0] cmd_a,
   input  logic [31:0] cmd_b,
   input  logic        cmd_cin,
   input  logic        cmd_wide,
   output logic [15:0] au_a,
   output logic [15:0] au_b,
   output logic [2:0]  au_code,
   output logic        au_cin,
   output logic        au_coe,
   input  logic [15:0] au_c,
   input  logic        au_vout,
   input  logic        au_cout,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_c,
   output logic        rsp_v,
   output logic        rsp_co,
   output logic        rsp_err
);

   localparam int CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t state, state_next;

   logic [2:0]        op_q;
   logic [31:0]       a_q, b_q;
   logic              cin_q, wide_q;
   logic [CNT_W-1:0]  cnt;
   logic              settle_done, wide_in;

   logic              map_pass, map_wide, map_cin;
   logic [2:0]        map_op;
   logic [31:0]       map_a, map_b;
   logic [15:0]       map_au_a, map_au_b;
   logic [2:0]        map_au_code;
   logic              map_au_cin;

   assign wide_in     = (WIDE_EN != 0) & cmd_wide;
   assign settle_done = (cnt == CNT_LAST);
   assign cmd_ready   = (state == IDLE);
   assign rsp_valid   = (state == RESP);
   assign au_coe      = 1'b0;

   // The mapper sees the live command while idle (pass 0 loaded on accept)
   // and the latched command otherwise (pass 1 loaded as LO expires). The
   // carry feeding the high pass is taken straight from the unit at that
   // edge; the registered au_cin then holds it for the whole high pass.
   assign map_pass = (state != IDLE);
   assign map_op   = map_pass ? op_q   : cmd_op;
   assign map_a    = map_pass ? a_q    : cmd_a;
   assign map_b    = map_pass ? b_q    : cmd_b;
   assign map_cin  = map_pass ? cin_q  : cmd_cin;
   assign map_wide = map_pass ? wide_q : wide_in;

   arith_op_map u_op_map (
      .op      (map_op),
      .wide    (map_wide),
      .pass    (map_pass),
      .carry   (au_cout),
      .cin     (map_cin),
      .a       (map_a),
      .b       (map_b),
      .au_a    (map_au_a),
      .au_b    (map_au_b),
      .au_code (map_au_code),
      .au_cin  (map_au_cin)
   );

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state decode: one or two settle windows, or straight to RESP.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (cmd_valid) state_next = op_illegal(cmd_op) ? RESP : LO;
         LO:   if (settle_done) state_next = wide_q ? HI : RESP;
         HI:   if (settle_done) state_next = RESP;
         RESP: if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Command latch, unit drive registers, settle counter and result capture.
   // NOTE: every register here is reset, so an aborted command leaves no
   // stale operands, codes or results visible after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         cin_q   <= 1'b0;
         wide_q  <= 1'b0;
         cnt     <= '0;
         au_a    <= '0;
         au_b    <= '0;
         au_code <= '0;
         au_cin  <= 1'b0;
         rsp_c   <= '0;
         rsp_v   <= 1'b0;
         rsp_co  <= 1'b0;
         rsp_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  op_q   <= cmd_op;
                  a_q    <= cmd_a;
                  b_q    <= cmd_b;
                  cin_q  <= cmd_cin;
                  wide_q <= wide_in;
                  cnt    <= CNT_ONE;
                  rsp_c  <= '0;
                  rsp_v  <= 1'b0;
                  rsp_co <= 1'b0;
                  if (op_illegal(cmd_op)) begin
                     rsp_err <= 1'b1;
                  end else begin
                     rsp_err <= 1'b0;
                     au_a    <= map_au_a;
                     au_b    <= map_au_b;
                     au_code <= map_au_code;
                     au_cin  <= map_au_cin;
                  end
               end
            end
            LO: begin
               if (settle_done) begin
                  rsp_c[15:0] <= au_c;
                  if (wide_q) begin
                     au_a    <= map_au_a;
                     au_b    <= map_au_b;
                     au_code <= map_au_code;
                     au_cin  <= map_au_cin;
                     cnt     <= CNT_ONE;
                  end else begin
                     rsp_v   <= au_vout;
                     rsp_co  <= au_cout;
                     au_a    <= '0;
                     au_b    <= '0;
                     au_code <= '0;
                     au_cin  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            HI: begin
               if (settle_done) begin
                  rsp_c[31:16] <= au_c;
                  rsp_v        <= au_vout;
                  rsp_co       <= au_cout;
                  au_a         <= '0;
                  au_b         <= '0;
                  au_code      <= '0;
                  au_cin       <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_arith_chain_ctrl.sv
// Self-checking bench for arith_chain_ctrl: a behavioural model of the
// 16-bit arithmetic unit closes the loop, and expected results come from
// whole-word arithmetic on the original command.
module tb_arith_chain_ctrl;

   localparam int S = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready;
   logic [2:0]  cmd_op;
   logic [31:0] cmd_a, cmd_b;
   logic        cmd_cin, cmd_wide;
   logic [15:0] au_a, au_b, au_c;
   logic [2:0]  au_code;
   logic        au_cin, au_coe, au_vout, au_cout;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_c;
   logic        rsp_v, rsp_co, rsp_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   arith_chain_ctrl #(.SETTLE_CYCLES(S), .WIDE_EN(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .cmd_cin   (cmd_cin),
      .cmd_wide  (cmd_wide),
      .au_a      (au_a),
      .au_b      (au_b),
      .au_code   (au_code),
      .au_cin    (au_cin),
      .au_coe    (au_coe),
      .au_c      (au_c),
      .au_vout   (au_vout),
      .au_cout   (au_cout),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_c     (rsp_c),
      .rsp_v     (rsp_v),
      .rsp_co    (rsp_co),
      .rsp_err   (rsp_err)
   );

   // Arithmetic unit model: everything is A + B' + c, with signed overflow
   // reported on vout for every code.
   logic [15:0] u_bop;
   logic [16:0] u_sum;
   always_comb begin
      u_bop = '0;
      u_sum = '0;
      case (au_code)
         3'b000, 3'b001: begin u_bop = au_b;     u_sum = {1'b0, au_a} + {1'b0, u_bop} + 17'(au_cin); end
         3'b010, 3'b011: begin u_bop = ~au_b;    u_sum = {1'b0, au_a} + {1'b0, u_bop} + 17'(au_cin); end
         3'b100:         begin u_bop = 16'h0000; u_sum = {1'b0, au_a} + 17'd1; end
         3'b101:         begin u_bop = 16'hFFFE; u_sum = {1'b0, au_a} + {1'b0, u_bop} + 17'd1; end
         default: ;
      endcase
      au_c    = u_sum[15:0];
      au_cout = u_sum[16];
      au_vout = (au_a[15] == u_bop[15]) && (u_sum[15] != au_a[15]);
   end

   typedef struct {
      logic [31:0] c;
      logic        v;
      logic        co;
      logic        err;
      int          lat;
   } exp_t;

   // Reference: whole-word arithmetic at 16 or 32 bits, latency by rule.
   function automatic exp_t ref_model(input logic [2:0] op, input logic [31:0] a, b,
                                      input logic cin, wide);
      exp_t        e;
      logic [32:0] s;
      logic [31:0] mask, am, bo;
      logic        ci;
      int          w;
      e.c = '0; e.v = 1'b0; e.co = 1'b0; e.err = 1'b0; e.lat = 1;
      if (op >= 3'd6) begin
         e.err = 1'b1;
         return e;
      end
      w    = wide ? 32 : 16;
      mask = wide ? 32'hFFFF_FFFF : 32'h0000_FFFF;
      case (op)
         3'd0, 3'd1: begin bo = b;      ci = cin;  end
         3'd2, 3'd3: begin bo = ~b;     ci = cin;  end
         3'd4:       begin bo = '0;     ci = 1'b1; end
         default:    begin bo = ~32'd1; ci = 1'b1; end
      endcase
      am    = a & mask;
      bo    = bo & mask;
      s     = {1'b0, am} + {1'b0, bo} + 33'(ci);
      e.c   = s[31:0] & mask;
      e.co  = s[w];
      e.v   = (am[w-1] == bo[w-1]) && (e.c[w-1] != am[w-1]);
      e.lat = 1 + S * (wide ? 2 : 1);
      return e;
   endfunction

   // Per-command observations gathered by run_cmd.
   logic [35:0] au_trace[$];
   logic        coe_bad;
   logic [31:0] r_c;
   logic        r_v, r_co, r_err, r_hold_ok;
   int          r_lat, r_wait;

   // Presents one command, records the unit drive each cycle, waits for the
   // response, applies bp cycles of backpressure (optionally with a stray
   // cmd_valid), then completes the handshake. Called and returns at a negedge.
   task automatic run_cmd(input logic [2:0] op, input logic [31:0] a, b,
                          input logic cin, wide, input int bp, input logic junk);
      au_trace.delete();
      coe_bad   = 1'b0;
      r_hold_ok = 1'b1;
      r_wait    = 0;
      r_lat     = -1;
      cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_wide = wide;
      cmd_valid = 1'b1;
      while (cmd_ready !== 1'b1 && r_wait < 20) begin
         @(negedge clk);
         r_wait++;
      end
      n_tests++;
      if (r_wait >= 20) begin
         $display("FAIL accept_timeout: cmd_ready=%b after 20 cycles, required 1", cmd_ready);
         n_fail++;
      end
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_op = 3'($urandom); cmd_a = $urandom; cmd_b = $urandom;
      cmd_cin = 1'($urandom); cmd_wide = 1'($urandom);
      for (int j = 0; j < 50; j++) begin
         au_trace.push_back({au_a, au_b, au_code, au_cin});
         if (au_coe !== 1'b0) coe_bad = 1'b1;
         if (rsp_valid === 1'b1) begin
            r_lat = j + 1;
            break;
         end
         @(negedge clk);
      end
      n_tests++;
      if (r_lat < 0) begin
         $display("FAIL rsp_timeout: rsp_valid=%b after 50 cycles, required 1", rsp_valid);
         n_fail++;
      end
      r_c = rsp_c; r_v = rsp_v; r_co = rsp_co; r_err = rsp_err;
      for (int k = 0; k < bp; k++) begin
         if (junk) begin
            cmd_valid = 1'b1;
            cmd_op    = 3'b111;
         end
         @(negedge clk);
         if (rsp_c !== r_c || rsp_v !== r_v || rsp_co !== r_co || rsp_err !== r_err ||
             rsp_valid !== 1'b1 || cmd_ready !== 1'b0)
            r_hold_ok = 1'b0;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
   endtask

   // Unit drive must be stable within each pass, carry the expected codes
   // and be all-zero once the response is up.
   function automatic logic trace_ok(input logic [2:0] op, input logic [31:0] a,
                                     input logic cin, wide, input int lat);
      logic [2:0] lo_code, hi_code;
      if (lat < 1 || au_trace.size() != lat) return 1'b0;
      if (au_trace[lat-1] !== 36'd0) return 1'b0;
      if (op >= 3'd6) return 1'b1;
      for (int j = 0; j < S; j++)
         if (au_trace[j] !== au_trace[0]) return 1'b0;
      if (au_trace[0][35:20] !== a[15:0]) return 1'b0;
      if (!wide) begin
         if (au_trace[0][3:1] !== op || au_trace[0][0] !== cin) return 1'b0;
      end else begin
         lo_code = (op == 3'd2 || op == 3'd3 || op == 3'd5) ? 3'b011 : 3'b001;
         hi_code = (op < 3'd4) ? op : ((op == 3'd4) ? 3'b000 : 3'b010);
         if (au_trace[0][3:1] !== lo_code) return 1'b0;
         for (int j = S; j < 2 * S; j++)
            if (au_trace[j] !== au_trace[S]) return 1'b0;
         if (au_trace[S][35:20] !== a[31:16] || au_trace[S][3:1] !== hi_code) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic test_reset();
      rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
      cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_cin = 1'b0; cmd_wide = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({cmd_ready, rsp_valid} !== 2'b10) begin
         $display("FAIL reset_handshake: ready/valid=%b required 10", {cmd_ready, rsp_valid});
         n_fail++;
      end
      n_tests++;
      if ({rsp_c, rsp_v, rsp_co, rsp_err} !== 35'd0) begin
         $display("FAIL reset_rsp: c=%h v=%b co=%b err=%b required all 0", rsp_c, rsp_v, rsp_co, rsp_err);
         n_fail++;
      end
      n_tests++;
      if ({au_a, au_b, au_code, au_cin, au_coe} !== 37'd0) begin
         $display("FAIL reset_au: a=%h b=%h code=%b cin=%b coe=%b required all 0",
                  au_a, au_b, au_code, au_cin, au_coe);
         n_fail++;
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_narrow_sadd();
      run_cmd(3'b000, 32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0);
      n_tests++;
      if (r_lat !== 1 + S) begin
         $display("FAIL sadd_latency: got %0d required %0d", r_lat, 1 + S);
         n_fail++;
      end
      n_tests++;
      if ({r_c, r_v, r_err} !== {32'h0000_8000, 1'b1, 1'b0}) begin
         $display("FAIL sadd_result: c=%h v=%b err=%b required 00008000 1 0", r_c, r_v, r_err);
         n_fail++;
      end
      n_tests++;
      if ({rsp_valid, cmd_ready} !== 2'b01) begin
         $display("FAIL sadd_release: valid/ready=%b required 01", {rsp_valid, cmd_ready});
         n_fail++;
      end
   endtask

   task automatic test_wide_uadd();
      run_cmd(3'b001, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1, 0, 1'b0);
      n_tests++;
      if (r_lat !== 1 + 2 * S) begin
         $display("FAIL wide_uadd_latency: got %0d required %0d", r_lat, 1 + 2 * S);
         n_fail++;
      end
      n_tests++;
      if ({r_c, r_co} !== {32'h0001_0000, 1'b0}) begin
         $display("FAIL wide_uadd_result: c=%h co=%b required 00010000 0", r_c, r_co);
         n_fail++;
      end
      n_tests++;
      if (au_trace.size() <= S || au_trace[S][0] !== 1'b1 || au_trace[0][3:1] !== 3'b001) begin
         $display("FAIL wide_uadd_chain: high-pass cin/low code not 1/001 (trace len %0d)", au_trace.size());
         n_fail++;
      end
   endtask

   task automatic test_wide_sub_dec();
      run_cmd(3'b010, 32'h0001_0000, 32'h0000_0001, 1'b1, 1'b1, 0, 1'b0);
      n_tests++;
      if ({r_c, r_co} !== {32'h0000_FFFF, 1'b1}) begin
         $display("FAIL wide_ssub_result: c=%h co=%b required 0000ffff 1", r_c, r_co);
         n_fail++;
      end
      run_cmd(3'b101, 32'h0001_0000, $urandom, 1'($urandom), 1'b1, 0, 1'b0);
      n_tests++;
      if ({r_c, r_v} !== {32'h0000_FFFF, 1'b0}) begin
         $display("FAIL wide_dec_result: c=%h v=%b required 0000ffff 0", r_c, r_v);
         n_fail++;
      end
   endtask

   task automatic test_backpressure();
      exp_t        e;
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      e = ref_model(3'b011, a, b, 1'b1, 1'b1);
      run_cmd(3'b011, a, b, 1'b1, 1'b1, 5, 1'b1);
      n_tests++;
      if (r_hold_ok !== 1'b1) begin
         $display("FAIL backpressure_hold: rsp_* or cmd_ready moved while stalled, required stable");
         n_fail++;
      end
      n_tests++;
      if ({r_c, r_v, r_co, r_err} !== {e.c, e.v, e.co, e.err}) begin
         $display("FAIL backpressure_result: c=%h v=%b co=%b required %h %b %b", r_c, r_v, r_co, e.c, e.v, e.co);
         n_fail++;
      end
      n_tests++;
      if ({rsp_valid, cmd_ready} !== 2'b01) begin
         $display("FAIL backpressure_no_early_accept: valid/ready=%b required 01", {rsp_valid, cmd_ready});
         n_fail++;
      end
   endtask

   task automatic test_illegal();
      for (int k = 0; k < 2; k++) begin
         logic [2:0] op;
         op = (k == 0) ? 3'b110 : 3'b111;
         run_cmd(op, $urandom, $urandom, 1'($urandom), 1'($urandom), 0, 1'b0);
         n_tests++;
         if (r_lat !== 1 || {r_err, r_c} !== {1'b1, 32'd0}) begin
            $display("FAIL illegal_%0d: lat=%0d err=%b c=%h required 1 1 00000000", k, r_lat, r_err, r_c);
            n_fail++;
         end
         n_tests++;
         if (!trace_ok(op, 32'd0, 1'b0, 1'b0, r_lat)) begin
            $display("FAIL illegal_au_%0d: unit drive not held at 0", k);
            n_fail++;
         end
      end
   endtask

   task automatic test_reset_mid();
      exp_t        e;
      logic [31:0] a, b;
      int          seen;
      cmd_op = 3'b001; cmd_a = $urandom; cmd_b = $urandom; cmd_cin = 1'b0; cmd_wide = 1'b1;
      cmd_valid = 1'b1;
      @(posedge clk);
      for (int j = 0; j <= S; j++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({rsp_valid, cmd_ready, au_a, au_b, au_code, au_cin, au_coe} !== {1'b0, 1'b1, 37'd0}) begin
         $display("FAIL reset_mid: valid=%b ready=%b au_a=%h au_b=%h code=%b cin=%b required 0 1 and au 0",
                  rsp_valid, cmd_ready, au_a, au_b, au_code, au_cin);
         n_fail++;
      end
      rst = 1'b0;
      seen = 0;
      for (int j = 0; j < 3 * S + 4; j++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) seen++;
      end
      n_tests++;
      if (seen != 0) begin
         $display("FAIL reset_mid_dropped: rsp_valid seen %0d cycles, required 0", seen);
         n_fail++;
      end
      a = $urandom; b = $urandom;
      e = ref_model(3'b000, a, b, 1'b1, 1'b1);
      run_cmd(3'b000, a, b, 1'b1, 1'b1, 0, 1'b0);
      n_tests++;
      if ({r_c, r_v, r_co, r_err} !== {e.c, e.v, e.co, e.err} || r_lat !== e.lat) begin
         $display("FAIL reset_mid_next: c=%h v=%b co=%b lat=%0d required %h %b %b %0d",
                  r_c, r_v, r_co, r_lat, e.c, e.v, e.co, e.lat);
         n_fail++;
      end
   endtask

   task automatic test_back_to_back();
      exp_t        e;
      logic [2:0]  op;
      logic [31:0] a, b;
      logic        cin, wide;
      for (int i = 0; i < 6; i++) begin
         op = 3'($urandom); a = $urandom; b = $urandom; cin = 1'($urandom); wide = 1'($urandom);
         e  = ref_model(op, a, b, cin, wide);
         run_cmd(op, a, b, cin, wide, 0, 1'b0);
         n_tests++;
         if (r_wait !== 0 || r_lat !== e.lat) begin
            $display("FAIL back_to_back_%0d: accept wait=%0d lat=%0d required 0 %0d", i, r_wait, r_lat, e.lat);
            n_fail++;
         end
         n_tests++;
         if ({r_c, r_v, r_co, r_err} !== {e.c, e.v, e.co, e.err}) begin
            $display("FAIL back_to_back_res_%0d: c=%h v=%b co=%b err=%b required %h %b %b %b",
                     i, r_c, r_v, r_co, r_err, e.c, e.v, e.co, e.err);
            n_fail++;
         end
      end
   endtask

   task automatic test_random();
      exp_t        e;
      logic [2:0]  op;
      logic [31:0] a, b;
      logic        cin, wide;
      int          bp;
      logic [31:0] corner [4];
      corner[0] = 32'h0000_7FFF; corner[1] = 32'h0000_FFFF;
      corner[2] = 32'h7FFF_FFFF; corner[3] = 32'hFFFF_FFFF;
      for (int i = 0; i < 40; i++) begin
         op   = 3'($urandom);
         a    = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
         b    = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
         cin  = 1'($urandom);
         wide = 1'($urandom);
         bp   = $urandom_range(0, 3);
         e    = ref_model(op, a, b, cin, wide);
         run_cmd(op, a, b, cin, wide, bp, 1'($urandom));
         n_tests++;
         if ({r_c, r_v, r_co, r_err} !== {e.c, e.v, e.co, e.err}) begin
            $display("FAIL random_%0d op=%b wide=%b a=%h b=%h cin=%b: c=%h v=%b co=%b err=%b required %h %b %b %b",
                     i, op, wide, a, b, cin, r_c, r_v, r_co, r_err, e.c, e.v, e.co, e.err);
            n_fail++;
         end
         n_tests++;
         if (r_lat !== e.lat) begin
            $display("FAIL random_lat_%0d: got %0d required %0d", i, r_lat, e.lat);
            n_fail++;
         end
         n_tests++;
         if (!trace_ok(op, a, cin, wide, r_lat) || coe_bad || !r_hold_ok) begin
            $display("FAIL random_au_%0d: drive/hold check failed (coe_bad=%b hold_ok=%b)", i, coe_bad, r_hold_ok);
            n_fail++;
         end
         n_tests++;
         if ({rsp_valid, cmd_ready} !== 2'b01) begin
            $display("FAIL random_release_%0d: valid/ready=%b required 01", i, {rsp_valid, cmd_ready});
            n_fail++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_narrow_sadd();
      test_wide_uadd();
      test_wide_sub_dec();
      test_backpressure();
      test_illegal();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
